// File: rtl/pi1_rrarb_pkg.sv
// Shared definitions for the pi1 round-robin arbiter: PerInt op encodings,
// FSM state type and the master-index width helper.
// No ports; imported by pi1_rrarb and pi1_rrpick.
package pi1_rrarb_pkg;

    // PerInt op encodings
    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Master index width; a single master still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pi1_rrpick.sv
// Combinational round-robin picker: selects the first requester after last_i.
// Ports: req_i (request per master), last_i (index served last),
//        gnt_o (one-hot pick), idx_o (picked index), vld_o (any request).
module pi1_rrpick
    import pi1_rrarb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    // Walk offsets 1..N from last_i so that last_i itself is checked last,
    // which gives the just-served master the lowest priority.
    always_comb begin
        int c;
        logic [IW-1:0] ci;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        ci    = '0;
        for (int off = 1; off <= N; off++) begin
            c = int'(last_i) + off;
            if (c >= N) c = c - N;
            ci = IW'(c);
            if (!vld_o && req_i[ci]) begin
                vld_o     = 1'b1;
                gnt_o[ci] = 1'b1;
                idx_o     = ci;
            end
        end
    end

endmodule

// File: rtl/pi1_rrarb.sv
// Round-robin arbiter sharing one pi1 slave port between MASTERCOUNT masters,
// one request outstanding at a time (IDLE -> BUSY -> DONE).
// Ports: m_* per-master request/completion, s_* slave port, gnt_o owner, timeout_o abort pulse.
// Optional watchdog: define PI1RRARB_TIMEOUT_EN to abort a BUSY op after 2**TIMEOUTBITSZ-1 cycles.
module pi1_rrarb
    import pi1_rrarb_pkg::*;
#(
    parameter  int MASTERCOUNT  = 2,
    parameter  int ARCHBITSZ    = 16,
    parameter  int TIMEOUTBITSZ = 10,
    localparam int SELBITSZ     = ARCHBITSZ / 8,
    localparam int ADDRBITSZ    = ARCHBITSZ - $clog2(SELBITSZ),
    localparam int IDXBITSZ     = idx_width(MASTERCOUNT)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [2*MASTERCOUNT-1:0]         m_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
    input  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i,
    output logic [ARCHBITSZ-1:0]             m_data_o,
    output logic [MASTERCOUNT-1:0]           m_rdy_o,
    output logic [1:0]                       s_op_o,
    output logic [ADDRBITSZ-1:0]             s_addr_o,
    output logic [ARCHBITSZ-1:0]             s_data_o,
    input  logic [ARCHBITSZ-1:0]             s_data_i,
    output logic [SELBITSZ-1:0]              s_sel_o,
    input  logic                             s_rdy_i,
    output logic [MASTERCOUNT-1:0]           gnt_o,
    output logic                             timeout_o
);

    state_t                  state_q, state_d;
    logic [IDXBITSZ-1:0]     last_q, last_d;
    logic [MASTERCOUNT-1:0]  gnt_q, gnt_d;
    logic [1:0]              op_q, op_d;
    logic [ADDRBITSZ-1:0]    addr_q, addr_d;
    logic [ARCHBITSZ-1:0]    wdata_q, wdata_d;
    logic [SELBITSZ-1:0]     sel_q, sel_d;
    logic [ARCHBITSZ-1:0]    rdata_q, rdata_d;

    logic [MASTERCOUNT-1:0]  req;
    logic [MASTERCOUNT-1:0]  pick_gnt;
    logic [IDXBITSZ-1:0]     pick_idx;
    logic                    pick_vld;
    logic [1:0]              pk_op;
    logic [ADDRBITSZ-1:0]    pk_addr;
    logic [ARCHBITSZ-1:0]    pk_wdata;
    logic [SELBITSZ-1:0]     pk_sel;

`ifdef PI1RRARB_TIMEOUT_EN
    logic [TIMEOUTBITSZ-1:0] wd_q, wd_d;
    logic                    to_q, to_d;
`endif

    always_comb begin
        req = '0;
        for (int m = 0; m < MASTERCOUNT; m++) begin
            req[m] = (m_op_i[2*m +: 2] != PINOOP);
        end
    end

    pi1_rrpick #(
        .N  (MASTERCOUNT),
        .IW (IDXBITSZ)
    ) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    // Request fields of the picked master.
    always_comb begin
        pk_op    = PINOOP;
        pk_addr  = '0;
        pk_wdata = '0;
        pk_sel   = '0;
        for (int m = 0; m < MASTERCOUNT; m++) begin
            if (pick_gnt[m]) begin
                pk_op    = m_op_i[2*m +: 2];
                pk_addr  = m_addr_i[ADDRBITSZ*m +: ADDRBITSZ];
                pk_wdata = m_data_i[ARCHBITSZ*m +: ARCHBITSZ];
                pk_sel   = m_sel_i[SELBITSZ*m +: SELBITSZ];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
`ifdef PI1RRARB_TIMEOUT_EN
        wd_d    = wd_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    op_d    = pk_op;
                    addr_d  = pk_addr;
                    wdata_d = pk_wdata;
                    sel_d   = pk_sel;
                    gnt_d   = pick_gnt;
                    last_d  = pick_idx;
                    state_d = ST_BUSY;
`ifdef PI1RRARB_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (s_rdy_i) begin
                    case (op_q)
                        PIRDOP, PIRWOP: rdata_d = s_data_i;
                        default:        rdata_d = '0;
                    endcase
                    state_d = ST_DONE;
                end
`ifdef PI1RRARB_TIMEOUT_EN
                else begin
                    // Abort on the cycle the counter would reach all-ones,
                    // so the slave sees exactly 2**TIMEOUTBITSZ-1 BUSY cycles.
                    wd_d = wd_q + 1'b1;
                    if (wd_d == '1) begin
                        rdata_d = '1;
                        to_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
`endif
            end
            ST_DONE: begin
                // No arbitration here: the owner's request is still on its port.
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= IDXBITSZ'(MASTERCOUNT - 1);
            gnt_q   <= '0;
            op_q    <= PINOOP;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef PI1RRARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    // Watchdog width is kept as a parameter so both builds share one interface.
    logic unused_timeoutbitsz;
    assign unused_timeoutbitsz = (TIMEOUTBITSZ > 0);
    assign timeout_o = 1'b0;
`endif

    assign s_op_o   = (state_q == ST_BUSY) ? op_q : PINOOP;
    assign s_addr_o = addr_q;
    assign s_data_o = wdata_q;
    assign s_sel_o  = sel_q;
    assign m_data_o = rdata_q;
    assign gnt_o    = gnt_q;
    assign m_rdy_o  = (state_q == ST_DONE) ? gnt_q : '0;

endmodule

// File: tb/tb_pi1_rrarb.sv
module tb_pi1_rrarb;

    localparam int MC = 4;
    localparam int AW = 16;
    localparam int AB = 15;
    localparam int SB = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2*MC-1:0] m_op;
    logic [AB*MC-1:0] m_addr;
    logic [AW*MC-1:0] m_wdat;
    logic [SB*MC-1:0] m_sel;
    logic [AW-1:0]   m_data;
    logic [MC-1:0]   m_rdy;
    logic [1:0]      s_op;
    logic [AB-1:0]   s_addr;
    logic [AW-1:0]   s_wdat;
    logic [AW-1:0]   s_rdata = '0;
    logic [SB-1:0]   s_sel;
    logic            s_rdy = 1'b0;
    logic [MC-1:0]   gnt;
    logic            timeout;

    logic [1:0]      mop   [MC];
    logic [AB-1:0]   maddr [MC];
    logic [AW-1:0]   mwd   [MC];
    logic [SB-1:0]   msel  [MC];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [MC-1:0] req;
        logic [1:0]    op;
        logic [AW-1:0] sdata;
        int            exp_idx;
        logic [AW-1:0] exp_data;
    } vec_t;
    vec_t vt [10];

    always #5 clk = ~clk;

    always_comb begin
        m_op = '0; m_addr = '0; m_wdat = '0; m_sel = '0;
        for (int m = 0; m < MC; m++) begin
            m_op[2*m +: 2]    = mop[m];
            m_addr[AB*m +: AB] = maddr[m];
            m_wdat[AW*m +: AW] = mwd[m];
            m_sel[SB*m +: SB]  = msel[m];
        end
    end

    pi1_rrarb #(
        .MASTERCOUNT  (MC),
        .ARCHBITSZ    (AW),
        .TIMEOUTBITSZ (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .m_op_i    (m_op),
        .m_addr_i  (m_addr),
        .m_data_i  (m_wdat),
        .m_sel_i   (m_sel),
        .m_data_o  (m_data),
        .m_rdy_o   (m_rdy),
        .s_op_o    (s_op),
        .s_addr_o  (s_addr),
        .s_data_o  (s_wdat),
        .s_data_i  (s_rdata),
        .s_sel_o   (s_sel),
        .s_rdy_i   (s_rdy),
        .gnt_o     (gnt),
        .timeout_o (timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_masters();
        for (int m = 0; m < MC; m++) begin
            mop[m] = 2'b00; maddr[m] = '0; mwd[m] = '0; msel[m] = '0;
        end
    endtask

    task automatic req(input int m, input logic [1:0] op, input logic [AB-1:0] a,
                       input logic [AW-1:0] d, input logic [SB-1:0] s);
        mop[m] = op; maddr[m] = a; mwd[m] = d; msel[m] = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_masters();
        s_rdy = 1'b0;
        s_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt"},     32'(gnt),     32'h0);
        chk({tag, " m_rdy"},   32'(m_rdy),   32'h0);
        chk({tag, " s_op"},    32'(s_op),    32'h0);
        chk({tag, " s_addr"},  32'(s_addr),  32'h0);
        chk({tag, " s_data"},  32'(s_wdat),  32'h0);
        chk({tag, " s_sel"},   32'(s_sel),   32'h0);
        chk({tag, " m_data"},  32'(m_data),  32'h0);
        chk({tag, " timeout"}, 32'(timeout), 32'h0);
    endtask

    // Reference round-robin rule: first requester after 'last', modulo MC.
    function automatic int rr_pick(input logic [MC-1:0] mask, input int last);
        for (int off = 1; off <= MC; off++) begin
            int c;
            c = (last + off) % MC;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [MC-1:0] onehot(input int idx);
        logic [MC-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic run_random(input int cycles);
        int mphase, owner, last, busy_wait, e;
        logic [MC-1:0] p_req;
        logic          p_srdy;
        logic [AW-1:0] p_sdata;
        bit            pend [MC];
        do_reset();
        mphase = 0; owner = 0; last = MC - 1; busy_wait = 0;
        p_req = '0; p_srdy = 1'b0; p_sdata = '0;
        for (int m = 0; m < MC; m++) pend[m] = 1'b0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            tick();
            chk("rnd timeout", 32'(timeout), 32'h0);
            if (mphase == 0) begin
                if (p_req != 0) begin
                    e = rr_pick(p_req, last);
                    chk("rnd grant",   32'(gnt),    32'(onehot(e)));
                    chk("rnd s_op",    32'(s_op),   32'(mop[e]));
                    chk("rnd s_addr",  32'(s_addr), 32'(maddr[e]));
                    chk("rnd s_data",  32'(s_wdat), 32'(mwd[e]));
                    chk("rnd s_sel",   32'(s_sel),  32'(msel[e]));
                    owner = e; last = e; mphase = 1; busy_wait = 0;
                end else begin
                    chk("rnd idle gnt",  32'(gnt),   32'h0);
                    chk("rnd idle s_op", 32'(s_op),  32'h0);
                    chk("rnd idle rdy",  32'(m_rdy), 32'h0);
                end
            end else if (mphase == 1) begin
                if (p_srdy) begin
                    chk("rnd m_rdy",  32'(m_rdy), 32'(onehot(owner)));
                    chk("rnd done gnt", 32'(gnt), 32'(onehot(owner)));
                    chk("rnd done s_op", 32'(s_op), 32'h0);
                    chk("rnd m_data", 32'(m_data),
                        (mop[owner] == 2'b01) ? 32'h0 : 32'(p_sdata));
                    pend[owner] = 1'b0;
                    mop[owner] = 2'b00;
                    mphase = 2;
                end else begin
                    chk("rnd busy rdy",  32'(m_rdy),  32'h0);
                    chk("rnd busy s_op", 32'(s_op),   32'(mop[owner]));
                    chk("rnd busy addr", 32'(s_addr), 32'(maddr[owner]));
                    busy_wait++;
                end
            end else begin
                chk("rnd post gnt", 32'(gnt),   32'h0);
                chk("rnd post rdy", 32'(m_rdy), 32'h0);
                mphase = 0;
            end
            for (int m = 0; m < MC; m++) begin
                if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    pend[m] = 1'b1;
                    req(m, 2'($urandom_range(1, 3)), AB'($urandom), AW'($urandom),
                        SB'($urandom));
                end
            end
            if (mphase == 1 && busy_wait >= 8) s_rdy = 1'b1;
            else s_rdy = 1'($urandom_range(0, 1));
            s_rdata = AW'($urandom);
            for (int m = 0; m < MC; m++) p_req[m] = (mop[m] != 2'b00);
            p_srdy = s_rdy;
            p_sdata = s_rdata;
        end
        clear_masters();
        s_rdy = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        int order [$];
        int busy;
        bit fin;

        vt[0] = '{4'b1111, 2'b10, 16'hBEEF, 0, 16'hBEEF};
        vt[1] = '{4'b1111, 2'b01, 16'h1234, 1, 16'h0000};
        vt[2] = '{4'b1111, 2'b11, 16'h5A5A, 2, 16'h5A5A};
        vt[3] = '{4'b1111, 2'b10, 16'h0F0F, 3, 16'h0F0F};
        vt[4] = '{4'b0100, 2'b01, 16'h1111, 2, 16'h0000};
        vt[5] = '{4'b0101, 2'b10, 16'h2222, 0, 16'h2222};
        vt[6] = '{4'b1010, 2'b11, 16'h3333, 1, 16'h3333};
        vt[7] = '{4'b0010, 2'b10, 16'h4444, 1, 16'h4444};
        vt[8] = '{4'b1001, 2'b01, 16'h5555, 3, 16'h0000};
        vt[9] = '{4'b0110, 2'b10, 16'h6666, 1, 16'h6666};

        // Reset values, then a single RD with a slow slave.
        clear_masters();
        tick();
        chk_all_zero("in reset");
        do_reset();
        chk_all_zero("after reset");
        req(0, 2'b10, 15'h10, 16'h0, 2'b11);
        tick();
        chk("t1 gnt", 32'(gnt), 32'h1);
        chk("t1 s_op", 32'(s_op), 32'h2);
        chk("t1 s_addr", 32'(s_addr), 32'h10);
        tick();
        chk("t1 wait rdy", 32'(m_rdy), 32'h0);
        chk("t1 wait s_op", 32'(s_op), 32'h2);
        tick();
        chk("t1 wait2 rdy", 32'(m_rdy), 32'h0);
        s_rdy = 1'b1; s_rdata = 16'hBEEF;
        tick();
        chk("t1 m_rdy", 32'(m_rdy), 32'h1);
        chk("t1 m_data", 32'(m_data), 32'hBEEF);
        chk("t1 done s_op", 32'(s_op), 32'h0);
        s_rdy = 1'b0; s_rdata = '0;
        clear_masters();
        tick();
        chk("t1 single pulse", 32'(m_rdy), 32'h0);
        chk("t1 gnt cleared", 32'(gnt), 32'h0);

        // Table of arbitration steps from reset (last starts at MC-1).
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int m = 0; m < MC; m++)
                if (vt[i].req[m]) req(m, vt[i].op, AB'(15'h100 + m), AW'(16'hA000 + m), 2'b11);
            tick();
            chk($sformatf("tbl%0d gnt", i), 32'(gnt), 32'(onehot(vt[i].exp_idx)));
            chk($sformatf("tbl%0d s_op", i), 32'(s_op), 32'(vt[i].op));
            chk($sformatf("tbl%0d s_addr", i), 32'(s_addr), 32'h100 + 32'(vt[i].exp_idx));
            s_rdy = 1'b1; s_rdata = vt[i].sdata;
            tick();
            chk($sformatf("tbl%0d m_rdy", i), 32'(m_rdy), 32'(onehot(vt[i].exp_idx)));
            chk($sformatf("tbl%0d m_data", i), 32'(m_data), 32'(vt[i].exp_data));
            s_rdy = 1'b0;
            clear_masters();
            tick();
            chk($sformatf("tbl%0d idle gnt", i), 32'(gnt), 32'h0);
        end

        // Master port changes after grant must not reach the slave.
        req(1, 2'b01, 15'h20, 16'h1234, 2'b10);
        tick();
        chk("t6 gnt", 32'(gnt), 32'h2);
        maddr[1] = 15'h7FF; msel[1] = 2'b01; mwd[1] = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t6 s_addr", 32'(s_addr), 32'h20);
            chk("t6 s_sel", 32'(s_sel), 32'h2);
            chk("t6 s_data", 32'(s_wdat), 32'h1234);
        end
        s_rdy = 1'b1;
        tick();
        chk("t6 m_rdy", 32'(m_rdy), 32'h2);
        chk("t6 wr m_data", 32'(m_data), 32'h0);
        s_rdy = 1'b0;
        clear_masters();
        tick();

        // Asynchronous reset while BUSY drops the op.
        req(2, 2'b10, 15'h42, 16'h0, 2'b01);
        tick();
        chk("t4 gnt2", 32'(gnt), 32'h4);
        req(0, 2'b10, 15'h40, 16'h0, 2'b11);
        req(3, 2'b10, 15'h43, 16'h0, 2'b11);
        tick();
        tick();
        chk("t4 busy", 32'(s_op), 32'h2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t4 async");
        tick();
        chk("t4 no rdy in reset", 32'(m_rdy), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t4 first after reset", 32'(gnt), 32'h1);
        s_rdy = 1'b1; s_rdata = 16'hCAFE;
        tick();
        chk("t4 m_rdy", 32'(m_rdy), 32'h1);
        s_rdy = 1'b0;
        clear_masters();
        tick();

        // Two masters writing continuously alternate.
        do_reset();
        req(0, 2'b01, 15'h30, 16'hAAAA, 2'b11);
        req(1, 2'b01, 15'h31, 16'hBBBB, 2'b11);
        s_rdy = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (m_rdy != 0) begin
                order.push_back((m_rdy == 4'b0001) ? 0 : (m_rdy == 4'b0010) ? 1 : 9);
                chk("t2 wr data", 32'(m_data), 32'h0);
            end
        end
        chk("t2 op count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++)
            chk($sformatf("t2 order%0d", i), 32'(order[i]), 32'(i % 2));
        s_rdy = 1'b0;
        clear_masters();
        tick();

`ifdef PI1RRARB_TIMEOUT_EN
        // Watchdog abort with a slave that never answers.
        do_reset();
        req(0, 2'b10, 15'h11, 16'h0, 2'b11);
        busy = 0;
        fin = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            tick();
            if (s_op != 2'b00) busy++;
            else if (busy > 0) begin
                fin = 1'b1;
                chk("t5 busy cycles", 32'(busy), 32'd15);
                chk("t5 timeout", 32'(timeout), 32'h1);
                chk("t5 m_rdy", 32'(m_rdy), 32'h1);
                chk("t5 m_data", 32'(m_data), 32'hFFFF);
            end
        end
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL t5 watchdog: no abort within 40 cycles, busy=%0d", busy);
        end
        clear_masters();
        tick();
        chk("t5 timeout pulse", 32'(timeout), 32'h0);
`endif

        run_random(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
